// File: rtl/cube_root_u8_if.sv
// Start/busy handshake bundle for the 8-bit cube-root unit.
interface cube_root_u8_if;
    logic [7:0] x_bi;
    logic       start_i;
    logic       busy_o;
    logic [7:0] y_bo;

    modport master (output x_bi, output start_i, input busy_o, input y_bo);
    modport slave  (input x_bi, input start_i, output busy_o, output y_bo);
endinterface

// File: rtl/cube_root_u8.sv
// Sequential floor(cbrt(x)) for an 8-bit operand using restoring
// shift-subtract digit recurrence, one root bit per clock.
module cube_root_u8 (
    input  logic          clk_i,
    input  logic          rst_i,
    cube_root_u8_if.slave bus
);
    localparam int unsigned XW = 8;
    localparam int unsigned SW = 4;
    localparam int unsigned BW = 16;

    typedef enum logic {IDLE, WORK} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] xr_q, xr_d;
    logic [XW-1:0] yr_q, yr_d;
    logic [XW-1:0] y_q, y_d;
    logic [SW-1:0] s_q, s_d;
    logic          busy_q, busy_d;
    logic [BW-1:0] y2;
    logic [BW-1:0] b;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            y_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            y_q     <= y_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
        end
    end

    // Trial subtrahend b = (3*y2*(y2+1) + 1) << s; peaks at 152, fits easily in BW.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        y_d     = y_q;
        s_d     = s_q;
        busy_d  = busy_q;
        y2      = BW'(yr_q) << 1;
        b       = (BW'(3) * y2 * (y2 + BW'(1)) + BW'(1)) << s_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start_i) begin
                    xr_d    = bus.x_bi;
                    yr_d    = '0;
                    s_d     = SW'(6);
                    busy_d  = 1'b1;
                    state_d = WORK;
                end
            end
            WORK: begin
                if (BW'(xr_q) >= b) begin
                    xr_d = xr_q - XW'(b);
                    yr_d = XW'(y2 + BW'(1));
                end else begin
                    yr_d = XW'(y2);
                end
                if (s_q == SW'(0)) begin
                    y_d     = yr_d;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    s_d = s_q - SW'(3);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o = busy_q;
    assign bus.y_bo   = y_q;
endmodule

// File: tb/tb_cube_root_u8.sv
// Directed self-checking bench for cube_root_u8 with an expected-result queue.
module tb_cube_root_u8;
    logic clk;
    logic rst;
    cube_root_u8_if ifc ();

    cube_root_u8 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb[$];

    function automatic logic [7:0] cbrt_ref(input int x);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i <= 6; i++)
            if (i * i * i <= x) r = 8'(i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            exp = sb.pop_front();
            check(tag, ifc.y_bo, exp);
        end
    endtask

    // One pulse-started computation; x_late is driven onto x_bi once accepted.
    task automatic run(input logic [7:0] x, input logic [7:0] x_late,
                       input string tag, output int cyc);
        @(negedge clk);
        ifc.x_bi    = x;
        ifc.start_i = 1'b1;
        sb.push_back(cbrt_ref(int'(x)));
        @(negedge clk);
        ifc.start_i = 1'b0;
        ifc.x_bi    = x_late;
        cyc = 0;
        while (ifc.busy_o === 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_busy_done"}, 8'(ifc.busy_o), 8'd0);
        check_result(tag);
    endtask

    int         cyc;
    logic [7:0] prev;
    logic [7:0] nc_x[8]   = '{8'd7, 8'd26, 8'd63, 8'd124, 8'd215, 8'd9, 8'd200, 8'd255};

    initial begin
        rst         = 1'b1;
        ifc.start_i = 1'b0;
        ifc.x_bi    = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_y", ifc.y_bo, 8'd0);
        check("reset_busy", 8'(ifc.busy_o), 8'd0);

        // Perfect cubes straight out of reset with start held high.
        for (int i = 0; i <= 6; i++) begin
            rst         = 1'b1;
            ifc.x_bi    = 8'(i * i * i);
            ifc.start_i = 1'b1;
            #1;
            check($sformatf("cube%0d_in_reset", i), ifc.y_bo, 8'd0);
            sb.push_back(cbrt_ref(i * i * i));
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            ifc.start_i = 1'b0;
            check($sformatf("cube%0d_busy", i), 8'(ifc.busy_o), 8'd0);
            check_result($sformatf("cube%0d", i));
            repeat (4) @(negedge clk);
        end

        foreach (nc_x[k]) run(nc_x[k], nc_x[k], $sformatf("noncube_x%0d", nc_x[k]), cyc);

        // Abort mid-computation: reset must clear outputs without a clock edge.
        @(negedge clk);
        ifc.x_bi    = 8'd216;
        ifc.start_i = 1'b1;
        sb.push_back(cbrt_ref(216));
        @(negedge clk);
        ifc.start_i = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 8'(ifc.busy_o), 8'd1);
        check("abort_y_before", ifc.y_bo, 8'd6);
        #2 rst = 1'b1;
        #1;
        check("abort_y_async", ifc.y_bo, 8'd0);
        check("abort_busy_async", 8'(ifc.busy_o), 8'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        run(8'd216, 8'd216, "abort_restart", cyc);

        // Single-cycle pulse; operand change during busy must be ignored.
        run(8'd125, 8'd8, "handshake", cyc);
        check("handshake_busy_cycles", 8'(cyc), 8'd3);

        // Start held high with stable operand: y_bo goes 5 -> 4 once, never glitches.
        prev = cbrt_ref(125);
        @(negedge clk);
        ifc.x_bi    = 8'd64;
        ifc.start_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("held_y_c%0d", k), ifc.y_bo, (k < 4) ? prev : cbrt_ref(64));
            check($sformatf("held_busy_c%0d", k), 8'(ifc.busy_o), (k % 4 != 0) ? 8'd1 : 8'd0);
        end
        ifc.start_i = 1'b0;
        repeat (4) @(negedge clk);

        for (int x = 0; x < 256; x++) run(8'(x), 8'(x), $sformatf("exh_x%0d", x), cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cube_root_u8.md
Name: cube_root_u8

Overview:
- Sequential integer cube-root unit: computes y = floor(cbrt(x)) for an unsigned 8-bit operand.
- Uses the restoring shift-subtract digit-recurrence method, one result bit per clock.
- Standalone arithmetic block with a start/busy handshake, driven by a controller or bench.
- Results range 0..6, since cbrt(255) < 7.

Parameters:
- None. Operand width is fixed at 8 bits and iteration count at 3.

Ports:
- clk_i    input   1  system clock; all state updates on the rising edge
- rst_i    input   1  asynchronous, active-high reset
- x_bi     input   8  unsigned radicand; sampled only when a start is accepted
- start_i  input   1  start request; level-sensitive, sampled in IDLE
- busy_o   output  1  high while a computation is in progress
- y_bo     output  8  floor cube root of the last accepted operand; upper 5 bits always 0

Behaviour:
- One clock; reset is asynchronous and active-high (rst_i).
- While rst_i=1: state=IDLE, busy_o=0, y_bo=0, all internal registers cleared. This takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-operation aborts the computation. No partial result ever appears on y_bo.
- Internal registers:
  - xr[7:0]: remaining radicand
  - yr[7:0]: partial root
  - s[3:0]: shift amount
- States: IDLE, WORK.
- IDLE:
  - busy_o=0.
  - If start_i=1 at a rising edge: xr<=x_bi, yr<=0, s<=6, go to WORK.
  - Otherwise remain in IDLE.
- WORK (one iteration per rising edge):
  - y2 = yr<<1
  - b = (3*y2*(y2+1) + 1) << s, computed in ≥16 bits. Maximum value is 152 at s=3, so no overflow.
  - If xr >= b: xr <= xr - b, yr <= y2+1. Else: yr <= y2.
  - If s==0: y_bo <= final yr value and state <= IDLE. Else: s <= s-3.
- busy_o=1 throughout WORK. It drops in the same edge that loads y_bo.
- Latency: start sampled at edge N. y_bo is valid and busy_o=0 after edge N+3, i.e. 4 edges total including the accept edge.
  - Hard requirement: result valid within 5 rising edges of reset release with start held high.
- y_bo holds its value between computations. It changes only on completion or reset.
- Start held continuously high:
  - The unit re-accepts at the first edge in IDLE and recomputes.
  - y_bo keeps its prior value during recomputation and is rewritten with the new result.
  - For a stable x_bi, y_bo does not glitch.
- start_i and x_bi changes during WORK are ignored. The operand is latched at accept.
- y_bo is driven from a register only, never combinationally from the datapath.

Test Plan:
- Perfect cubes: for i=0..6, assert reset, apply x=i^3 (0,1,8,27,64,125,216), release reset with start=1. Wait 5 edges -> y_bo=i and busy_o=0.
- Non-cubes: x=7->1, x=26->2, x=63->3, x=124->4, x=215->5, x=255->6, x=9->2, x=200->5.
- Reset during WORK: start x=216, assert rst_i after 2 edges -> y_bo=0 and busy_o=0 immediately, with no clock edge needed. Release and restart -> 6.
- Handshake: a single-cycle start pulse with x=125 -> busy_o=1 for exactly 3 cycles, then y_bo=5. Changing x_bi to 8 during busy does not affect the result (still 5).
- Start held high with stable x=64 over 20 cycles -> y_bo remains 4 after the first completion, with no intermediate values.
- Exhaustive: all x in 0..255 compared against floor(cbrt(x)) -> zero mismatches.
